// File: rtl/spi_pwm_master.sv
// SPI initiator for the 7-channel SPI PWM driver: turns write/read level requests
// into framed, slowed-down SPI transactions (sclk phases stretched over CLK_DIV clk cycles).
module spi_pwm_master #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_IDLE  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [2:0] req_addr,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       sclk,
    output logic       cs,
    output logic       mosi,
    input  logic       miso
);

    localparam int unsigned CW = 8;
    localparam int unsigned PW = 5;
    localparam int unsigned SW = 24;
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] IDLE_LAST  = CW'(CS_IDLE - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, HOLD, GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [PW-1:0] per, per_n;
    logic [SW-1:0] sh, sh_n;
    logic [7:0]    rx, rx_n;
    logic          wr, wr_n;
    logic          req_ready_n, rsp_valid_n, busy_n, sclk_n, cs_n, mosi_n;
    logic [7:0]    rsp_data_n;
    logic [PW-1:0] last_per;

    assign last_per = wr ? PW'(16) : PW'(17);

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            per       <= '0;
            sh        <= '0;
            rx        <= '0;
            wr        <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            sclk      <= 1'b0;
            cs        <= 1'b1;
            mosi      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            per       <= per_n;
            sh        <= sh_n;
            rx        <= rx_n;
            wr        <= wr_n;
            req_ready <= req_ready_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
            busy      <= busy_n;
            sclk      <= sclk_n;
            cs        <= cs_n;
            mosi      <= mosi_n;
        end
    end

    // Next-state and next-output logic; sh[SW-1] is the bit currently on mosi
    always_comb begin
        state_n     = state;
        cnt_n       = cnt + CW'(1);
        per_n       = per;
        sh_n        = sh;
        rx_n        = rx;
        wr_n        = wr;
        req_ready_n = req_ready;
        rsp_valid_n = 1'b0;
        rsp_data_n  = rsp_data;
        busy_n      = busy;
        sclk_n      = sclk;
        cs_n        = cs;
        mosi_n      = mosi;
        case (state)
            IDLE: begin
                cnt_n       = '0;
                req_ready_n = 1'b1;
                if (req_valid && req_ready) begin
                    state_n     = SETUP;
                    wr_n        = req_write;
                    sh_n        = {req_write, 4'b0000, req_addr,
                                   (req_write ? req_data : 8'h00), 8'h00};
                    rx_n        = '0;
                    per_n       = PW'(1);
                    cs_n        = 1'b0;
                    mosi_n      = req_write;
                    busy_n      = 1'b1;
                    req_ready_n = 1'b0;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_n = SCK_HI;
                    cnt_n   = '0;
                    sclk_n  = 1'b1;
                end
            end
            SCK_HI: begin
                if (cnt == HALF_LAST) begin
                    state_n = SCK_LO;
                    cnt_n   = '0;
                    sclk_n  = 1'b0;
                    sh_n    = {sh[SW-2:0], 1'b0};
                    mosi_n  = sh[SW-2];
                end
            end
            SCK_LO: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    if (per == last_per) begin
                        state_n = HOLD;
                    end else begin
                        state_n = SCK_HI;
                        sclk_n  = 1'b1;
                        per_n   = per + PW'(1);
                        // Rising edges of periods 10..17 carry the read byte
                        if (!wr && per >= PW'(9)) begin
                            rx_n = {rx[6:0], miso};
                        end
                    end
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_n     = GAP;
                    cnt_n       = '0;
                    cs_n        = 1'b1;
                    mosi_n      = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_data_n  = wr ? 8'h00 : rx;
                end
            end
            GAP: begin
                if (cnt == IDLE_LAST) begin
                    state_n     = IDLE;
                    cnt_n       = '0;
                    req_ready_n = 1'b1;
                    busy_n      = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_pwm_master.sv
// Self-checking bench for spi_pwm_master: table of write/read transactions against a
// serial slave model, plus back-to-back and mid-frame reset sequences.
module tb_spi_pwm_master;

    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned CS_SETUP = 2;
    localparam int unsigned CS_HOLD  = 2;
    localparam int unsigned CS_IDLE  = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_valid, req_ready, req_write;
    logic [2:0] req_addr;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy, sclk, cs, mosi, miso;

    always #5 clk = ~clk;

    spi_pwm_master #(
        .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Serial-side monitor and slave model, sampled on the falling clk edge
    int          rises = 0, falls = 0, setup_lo = 0, hold_lo = 0, frames = 0, gap_hi = 0;
    logic [31:0] bits = '0;
    logic [31:0] fbits [16];
    int          fgap  [16];
    logic        cs_q = 1'b1, sclk_q = 1'b0;
    logic [7:0]  slave_byte = 8'h00;
    logic [2:0]  miso_idx;

    assign miso_idx = 3'(16 - rises);
    assign miso = (rises >= 9 && rises <= 16) ? slave_byte[miso_idx] : 1'b0;

    always @(negedge clk) begin
        if (cs_q && !cs) begin
            if (frames < 16) fgap[frames] = gap_hi;
            frames++;
            rises = 0; falls = 0; bits = '0; setup_lo = 0; hold_lo = 0;
        end
        if (!cs) begin
            if (sclk && !sclk_q) begin
                rises++;
                bits = {bits[30:0], mosi};
            end
            if (!sclk && sclk_q) begin
                falls++;
                hold_lo = 0;
            end
            if (!sclk && rises == 0) setup_lo++;
            if (!sclk && falls > 0) hold_lo++;
        end
        if (!cs_q && cs && frames > 0 && frames <= 16) fbits[frames-1] = bits;
        gap_hi = cs ? (cs_q ? gap_hi + 1 : 1) : 0;
        cs_q   = cs;
        sclk_q = sclk;
    end

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [7:0]  data;
        logic [7:0]  slave;
        logic [31:0] exp_bits;
        int          exp_rises;
        logic [7:0]  exp_rsp;
        int          exp_rsp_cyc;
        int          exp_rdy_cyc;
    } vec_t;

    vec_t vecs [7];

    task automatic wait_ready(input string name);
        int k = 0;
        while (!req_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) chk({name, "_ready_timeout"}, 32'(req_ready), 32'd1);
    endtask

    task automatic run_txn(input vec_t v, input string name);
        int         cyc = 1;
        int         rsp_cyc = -1;
        int         rdy_cyc = -1;
        int         pulses = 0;
        logic [7:0] rd = 8'h00;
        slave_byte = v.slave;
        wait_ready(name);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_data  = v.data;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = ~v.wr;
        req_addr  = ~v.addr;
        req_data  = ~v.data;
        chk({name, "_busy_start"}, 32'(busy), 32'd1);
        while (cyc < 400) begin
            if (rsp_valid) begin
                pulses++;
                if (rsp_cyc < 0) begin
                    rsp_cyc = cyc;
                    rd = rsp_data;
                end
            end
            if (req_ready) begin
                rdy_cyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        chk({name, "_rises"},    32'(rises),    32'(v.exp_rises));
        chk({name, "_falls"},    32'(falls),    32'(v.exp_rises));
        chk({name, "_mosi"},     bits,          v.exp_bits);
        chk({name, "_rsp_data"}, 32'(rd),       32'(v.exp_rsp));
        chk({name, "_rsp_cyc"},  32'(rsp_cyc),  32'(v.exp_rsp_cyc));
        chk({name, "_rdy_cyc"},  32'(rdy_cyc),  32'(v.exp_rdy_cyc));
        chk({name, "_pulses"},   32'(pulses),   32'd1);
        chk({name, "_setup"},    32'(setup_lo), 32'(CS_SETUP));
        chk({name, "_hold"},     32'(hold_lo),  32'(CLK_DIV + CS_HOLD));
        chk({name, "_busy_end"}, 32'(busy),     32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] b_addr [3];
        logic [7:0] b_data [3];
        int         f0;
        int         k;
        int         pulses;

        vecs[0] = '{1'b1, 3'd3, 8'h80, 8'h00, 32'h0000_8380, 16, 8'h00, 133, 135};
        vecs[1] = '{1'b0, 3'd5, 8'h5A, 8'hA5, 32'h0000_0A00, 17, 8'hA5, 141, 143};
        vecs[2] = '{1'b1, 3'd7, 8'hFF, 8'h00, 32'h0000_87FF, 16, 8'h00, 133, 135};
        vecs[3] = '{1'b0, 3'd0, 8'hFF, 8'h3C, 32'h0000_0000, 17, 8'h3C, 141, 143};
        vecs[4] = '{1'b0, 3'd6, 8'h00, 8'h01, 32'h0000_0C00, 17, 8'h01, 141, 143};
        vecs[5] = '{1'b1, 3'd0, 8'h01, 8'h00, 32'h0000_8001, 16, 8'h00, 133, 135};
        vecs[6] = '{1'b0, 3'd7, 8'h00, 8'h80, 32'h0000_0E00, 17, 8'h80, 141, 143};

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 3'd0;
        req_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_cs",        32'(cs),        32'd1);
        chk("rst_sclk",      32'(sclk),      32'd0);
        chk("rst_mosi",      32'(mosi),      32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data",  32'(rsp_data),  32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back writes with req_valid held; inputs change while each frame runs
        b_addr[0] = 3'd1; b_data[0] = 8'h11;
        b_addr[1] = 3'd2; b_data[1] = 8'h22;
        b_addr[2] = 3'd4; b_data[2] = 8'h44;
        f0 = frames;
        req_valid = 1'b1;
        req_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr = b_addr[i];
            req_data = b_data[i];
            wait_ready("b2b");
            @(negedge clk);
        end
        req_valid = 1'b0;
        req_data  = 8'hEE;
        req_addr  = 3'd6;
        wait_ready("b2b_end");
        chk("b2b_frames", 32'(frames - f0), 32'd3);
        chk("b2b_bits0",  fbits[f0],     32'h0000_8111);
        chk("b2b_bits1",  fbits[f0 + 1], 32'h0000_8222);
        chk("b2b_bits2",  fbits[f0 + 2], 32'h0000_8444);
        chk("b2b_gap1",   32'(fgap[f0 + 1]), 32'(CS_IDLE + 1));
        chk("b2b_gap2",   32'(fgap[f0 + 2]), 32'(CS_IDLE + 1));

        // Reset during the high phase of period 9 of a write (first data bit = 1)
        wait_ready("rst_mid");
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 3'd2;
        req_data  = 8'hAA;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!(rises == 9 && sclk) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("mid_reached_p9",  32'(rises), 32'd9);
        chk("mid_pre_mosi",    32'(mosi),  32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_cs",   32'(cs),   32'd1);
        chk("mid_rst_sclk", 32'(sclk), 32'd0);
        chk("mid_rst_mosi", 32'(mosi), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        chk("mid_no_rsp", 32'(pulses), 32'd0);
        run_txn(vecs[0], "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
